// File: rtl/rom_port_pkg.sv
// Shared types and constants for the ROM host port and its boot-time
// integrity scan.
//   scan_state_e : boot scan FSM states
//   tag_e        : origin of a macro read travelling down the return path
//   ChkWidth     : width of the rotating checksum accumulator
//   chk_step     : one accumulator update (rotate left by one, then XOR word)
package rom_port_pkg;

  typedef enum logic [1:0] {
    SCAN_ISSUE = 2'd0,
    SCAN_DRAIN = 2'd1,
    DONE       = 2'd2
  } scan_state_e;

  typedef enum logic {
    TAG_HOST = 1'b0,
    TAG_SCAN = 1'b1
  } tag_e;

  localparam int unsigned ChkWidth = 32;

  function automatic logic [ChkWidth-1:0] chk_step(input logic [ChkWidth-1:0] acc,
                                                   input logic [ChkWidth-1:0] data);
    return {acc[ChkWidth-2:0], acc[ChkWidth-1]} ^ data;
  endfunction

endpackage

// File: rtl/rom_port_rsp_pipe.sv
// Fixed-depth delay line for host read responses (valid + data).
//   clk_i, rst_ni : clock, async active-low reset (all stages clear to 0)
//   valid_i/data_i: response as it leaves the ROM macro
//   valid_o/data_o: same response delayed by Depth cycles
// Depth == 0 is a pure wire so the top can use it for every Latency.
module rom_port_rsp_pipe #(
  parameter int unsigned Depth     = 0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end else begin : g_stages
    localparam int unsigned DataBits = Depth * DataWidth;

    // Index 0 is the youngest stage; the concatenation shifts in at the LSB
    // end and the cast drops the oldest entry.
    logic [Depth-1:0]                vld_q;
    logic [Depth-1:0][DataWidth-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q  <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= Depth'({vld_q, valid_i});
        data_q <= DataBits'({data_q, data_i});
      end
    end

    assign valid_o = vld_q[Depth-1];
    assign data_o  = data_q[Depth-1];
  end

endmodule

// File: rtl/rom_port.sv
// Host read port in front of a single-port ROM macro, plus a background boot
// scan that reads every word once and checks a rotating XOR checksum.
//   clk_i, rst_ni  : clock, async active-low reset
//   req_i, addr_i  : host read request (always accepted) and word address
//   rvalid_o       : host data valid, Latency cycles after the request
//   rdata_o        : host data, 0 while rvalid_o is low
//   mem_req_o      : ROM macro read strobe
//   mem_addr_o     : ROM macro word address (0 when idle)
//   mem_rdata_i    : ROM macro data, one cycle after mem_req_o
//   check_done_o   : boot scan finished (sticky until reset)
//   check_pass_o   : scan checksum equalled ExpChecksum
//   alert_o        : one-cycle pulse when the scan checksum mismatches
module rom_port
  import rom_port_pkg::*;
#(
  parameter int unsigned         AddrWidth   = 12,
  parameter int unsigned         DataWidth   = 32,
  parameter int unsigned         Latency     = 1,   // legal range 1..4
  parameter logic [ChkWidth-1:0] ExpChecksum = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 check_done_o,
  output logic                 check_pass_o,
  output logic                 alert_o
);

  scan_state_e          state_q;
  logic [AddrWidth-1:0] scan_addr_q;
  logic [ChkWidth-1:0]  acc_q;
  logic [ChkWidth-1:0]  acc_d;
  logic                 done_q;
  logic                 pass_q;
  logic                 alert_q;

  logic                 rd_vld_q;
  tag_e                 rd_tag_q;

  logic                 scan_issue;
  logic                 host_ret;
  logic                 scan_ret;
  logic [DataWidth-1:0] host_data;

  // Host always wins the macro; the scan only uses otherwise idle cycles.
  assign scan_issue = (state_q == SCAN_ISSUE) && !req_i;
  assign mem_req_o  = req_i || scan_issue;

  always_comb begin
    mem_addr_o = '0;
    if (req_i) begin
      mem_addr_o = addr_i;
    end else if (scan_issue) begin
      mem_addr_o = scan_addr_q;
    end
  end

  // Tag travels with the read so the return cycle knows who asked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= TAG_HOST;
    end else begin
      rd_vld_q <= mem_req_o;
      rd_tag_q <= req_i ? TAG_HOST : TAG_SCAN;
    end
  end

  assign host_ret  = rd_vld_q && (rd_tag_q == TAG_HOST);
  assign scan_ret  = rd_vld_q && (rd_tag_q == TAG_SCAN);
  assign host_data = host_ret ? mem_rdata_i : '0;
  assign acc_d     = chk_step(acc_q, mem_rdata_i[ChkWidth-1:0]);

  // Scan FSM. The drain state waits for the return of the final scan read;
  // the pass/fail decision uses the accumulator including that last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SCAN_ISSUE;
      scan_addr_q <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      alert_q <= 1'b0;
      if (scan_ret) begin
        acc_q <= acc_d;
      end
      case (state_q)
        SCAN_ISSUE: begin
          if (scan_issue) begin
            scan_addr_q <= scan_addr_q + AddrWidth'(1);
            if (&scan_addr_q) begin
              state_q <= SCAN_DRAIN;
            end
          end
        end
        SCAN_DRAIN: begin
          if (scan_ret) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (acc_d == ExpChecksum);
            alert_q <= (acc_d != ExpChecksum);
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= SCAN_ISSUE;
        end
      endcase
    end
  end

  assign check_done_o = done_q;
  assign check_pass_o = pass_q;
  assign alert_o      = alert_q;

  rom_port_rsp_pipe #(
    .Depth     (Latency - 1),
    .DataWidth (DataWidth)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (host_ret),
    .data_i  (host_data),
    .valid_o (rvalid_o),
    .data_o  (rdata_o)
  );

endmodule

// File: tb/tb_rom_port.sv
// Bench for rom_port: two instances (Latency 1 and 3, different expected
// checksums) share host stimulus; each has its own ROM macro model.
module tb_rom_port;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] EXP1 = 32'h8000_0000;
  localparam logic [31:0] EXP3 = 32'h0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req   = 1'b0;
  logic [AW-1:0] addr  = '0;

  logic          rv1, rv3, mreq1, mreq3;
  logic [DW-1:0] rd1, rd3, mrd1, mrd3;
  logic [AW-1:0] maddr1, maddr3;
  logic          done1, pass1, alert1, done3, pass3, alert3;

  logic [DW-1:0] rom [4096];
  logic [DW-1:0] exp1 [int];
  logic [DW-1:0] exp3 [int];

  int cyc  = 0;
  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM macro models: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    mrd1 <= mreq1 ? rom[maddr1] : $urandom();
    mrd3 <= mreq3 ? rom[maddr3] : $urandom();
  end

  rom_port #(.AddrWidth(AW), .DataWidth(DW), .Latency(1), .ExpChecksum(EXP1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
    .rvalid_o(rv1), .rdata_o(rd1), .mem_req_o(mreq1), .mem_addr_o(maddr1),
    .mem_rdata_i(mrd1), .check_done_o(done1), .check_pass_o(pass1), .alert_o(alert1));

  rom_port #(.AddrWidth(AW), .DataWidth(DW), .Latency(3), .ExpChecksum(EXP3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
    .rvalid_o(rv3), .rdata_o(rd3), .mem_req_o(mreq3), .mem_addr_o(maddr3),
    .mem_rdata_i(mrd3), .check_done_o(done3), .check_pass_o(pass3), .alert_o(alert3));

  // Checksum over the whole ROM: rotate left by one, XOR next word.
  function automatic logic [31:0] model_sum();
    logic [31:0] a = '0;
    for (int i = 0; i < 4096; i++) a = ((a << 1) | (a >> 31)) ^ rom[AW'(i)];
    return a;
  endfunction

  // Drive host inputs for the coming edge and record the expected response
  // (sampled Latency negedges later).
  task automatic drive(input logic r, input logic [AW-1:0] a);
    req  = r;
    addr = a;
    if (r) begin
      exp1[cyc + 1] = rom[a];
      exp3[cyc + 3] = rom[a];
    end
    #1;
  endtask

  task automatic do_reset();
    req = 1'b0;
    addr = '0;
    rst_n = 1'b0;
    exp1.delete();
    exp3.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one full scan from reset release, optionally with a burst of host
  // requests. Returns observations; callers do the comparisons.
  task automatic run_scan(input int hstart, input int hcount,
                          output int dk1, output int dk3, output int na1, output int na3,
                          output int ak1, output int ak3, output int rsp_err, output int scan_err);
    int nidle = 0;
    logic h, ev;
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    dk1 = -1; dk3 = -1; na1 = 0; na3 = 0; ak1 = -1; ak3 = -1; rsp_err = 0; scan_err = 0;
    do_reset();
    for (int k = 1; k <= 4300; k++) begin
      h = (k - 1 >= hstart) && (k - 1 < hstart + hcount);
      a = AW'($urandom);
      drive(h, a);
      if (h) begin
        if (mreq1 !== 1'b1 || maddr1 !== a || mreq3 !== 1'b1 || maddr3 !== a) scan_err++;
      end else if (nidle < 4096) begin
        if (mreq1 !== 1'b1 || maddr1 !== AW'(nidle) || mreq3 !== 1'b1 || maddr3 !== AW'(nidle))
          scan_err++;
        nidle++;
      end else if (mreq1 !== 1'b0 || maddr1 !== '0 || mreq3 !== 1'b0 || maddr3 !== '0) begin
        scan_err++;
      end
      @(negedge clk);
      ev = (exp1.exists(cyc) != 0); ed = ev ? exp1[cyc] : '0;
      if (rv1 !== ev || rd1 !== ed) rsp_err++;
      ev = (exp3.exists(cyc) != 0); ed = ev ? exp3[cyc] : '0;
      if (rv3 !== ev || rd3 !== ed) rsp_err++;
      if (done1 === 1'b1 && dk1 < 0) dk1 = k;
      if (done3 === 1'b1 && dk3 < 0) dk3 = k;
      if (alert1 === 1'b1) begin na1++; ak1 = k; end
      if (alert3 === 1'b1) begin na3++; ak3 = k; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) rom[AW'(i)] = $urandom();
    repeat (3) @(negedge clk);
    nchk++;
    if ({rv1, rd1, done1, pass1, alert1} !== '0)
      $display("FAIL reset_outs1 got v=%0b d=%h done=%0b pass=%0b alert=%0b exp all 0",
               rv1, rd1, done1, pass1, alert1);
    else npass++;
    nchk++;
    if ({rv3, rd3, done3, pass3, alert3} !== '0)
      $display("FAIL reset_outs3 got v=%0b d=%h done=%0b pass=%0b alert=%0b exp all 0",
               rv3, rd3, done3, pass3, alert3);
    else npass++;
    rst_n = 1'b1;
    exp1.delete();
    exp3.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0);
      nchk++;
      if (mreq1 !== 1'b1 || maddr1 !== AW'(k))
        $display("FAIL first_scan_addr k=%0d got req=%0b addr=%0d exp req=1 addr=%0d", k, mreq1, maddr1, k);
      else npass++;
      @(negedge clk);
    end
  endtask

  task automatic test_latency1();
    rom[5] = 32'hDEAD_BEEF;
    drive(1'b1, AW'(5));
    nchk++;
    if (mreq1 !== 1'b1 || maddr1 !== AW'(5))
      $display("FAIL host_prio got req=%0b addr=%0d exp req=1 addr=5", mreq1, maddr1);
    else npass++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b0, '0);
      nchk++;
      if (rv1 !== (k == 1) || rd1 !== ((k == 1) ? 32'hDEAD_BEEF : 32'h0))
        $display("FAIL lat1_rsp k=%0d got v=%0b d=%h exp v=%0b d=%h", k, rv1, rd1,
                 (k == 1), ((k == 1) ? 32'hDEAD_BEEF : 32'h0));
      else npass++;
    end
  endtask

  task automatic test_latency3();
    logic ev;
    logic [DW-1:0] ed;
    int j;
    for (int i = 1; i <= 3; i++) rom[AW'(i)] = $urandom();
    for (int k = 0; k < 8; k++) begin
      drive(k < 3, (k < 3) ? AW'(k + 1) : '0);
      @(negedge clk);
      j = k + 1;
      ev = (j >= 3 && j <= 5);
      ed = ev ? rom[AW'(j - 2)] : '0;
      nchk++;
      if (rv3 !== ev || rd3 !== ed)
        $display("FAIL lat3_rsp j=%0d got v=%0b d=%h exp v=%0b d=%h", j, rv3, rd3, ev, ed);
      else npass++;
    end
    drive(1'b0, '0);
  endtask

  task automatic test_back_to_back_random();
    logic r, ev;
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    for (int i = 0; i < 4096; i++) rom[AW'(i)] = $urandom();
    for (int k = 0; k < 200; k++) begin
      r = (k < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      a = AW'($urandom);
      drive(r, a);
      if (r) begin
        nchk++;
        if (mreq1 !== 1'b1 || maddr1 !== a || mreq3 !== 1'b1 || maddr3 !== a)
          $display("FAIL rnd_mem_addr got %0d/%0d exp %0d", maddr1, maddr3, a);
        else npass++;
      end
      @(negedge clk);
      ev = (exp1.exists(cyc) != 0); ed = ev ? exp1[cyc] : '0;
      nchk++;
      if (rv1 !== ev || rd1 !== ed)
        $display("FAIL rnd_rsp1 cyc=%0d got v=%0b d=%h exp v=%0b d=%h", cyc, rv1, rd1, ev, ed);
      else npass++;
      ev = (exp3.exists(cyc) != 0); ed = ev ? exp3[cyc] : '0;
      nchk++;
      if (rv3 !== ev || rd3 !== ed)
        $display("FAIL rnd_rsp3 cyc=%0d got v=%0b d=%h exp v=%0b d=%h", cyc, rv3, rd3, ev, ed);
      else npass++;
    end
    drive(1'b0, '0);
  endtask

  // Shared expectations for one scan scenario, written out per test.
  task automatic test_checksum_pass();
    int dk1, dk3, na1, na3, ak1, ak3, re, se;
    logic [31:0] sum;
    logic ep1, ep3;
    for (int i = 0; i < 4096; i++) rom[AW'(i)] = '0;
    rom[0] = 32'h1;
    sum = model_sum();
    ep1 = (sum == EXP1);
    ep3 = (sum == EXP3);
    run_scan(0, 0, dk1, dk3, na1, na3, ak1, ak3, re, se);
    nchk++;
    if (dk1 !== 4097 || pass1 !== ep1 || na1 !== 0)
      $display("FAIL cks_pass_dut1 got t=%0d pass=%0b alerts=%0d exp t=4097 pass=%0b alerts=0",
               dk1, pass1, na1, ep1);
    else npass++;
    nchk++;
    if (dk3 !== 4097 || pass3 !== ep3 || na3 !== (ep3 ? 0 : 1) || (!ep3 && ak3 !== 4097))
      $display("FAIL cks_pass_dut3 got t=%0d pass=%0b alerts=%0d at %0d exp t=4097 pass=%0b",
               dk3, pass3, na3, ak3, ep3);
    else npass++;
    nchk++;
    if (re !== 0) $display("FAIL cks_pass_rsp got %0d errors exp 0", re); else npass++;
    nchk++;
    if (se !== 0) $display("FAIL cks_pass_mem got %0d errors exp 0", se); else npass++;
  endtask

  task automatic test_checksum_fail();
    int dk1, dk3, na1, na3, ak1, ak3, re, se;
    logic [31:0] sum;
    logic ep1, ep3;
    for (int i = 0; i < 4096; i++) rom[AW'(i)] = '0;
    rom[4095] = 32'h1;
    sum = model_sum();
    ep1 = (sum == EXP1);
    ep3 = (sum == EXP3);
    run_scan(0, 0, dk1, dk3, na1, na3, ak1, ak3, re, se);
    nchk++;
    if (dk1 !== 4097 || pass1 !== ep1 || na1 !== (ep1 ? 0 : 1) || (!ep1 && ak1 !== 4097))
      $display("FAIL cks_fail_dut1 got t=%0d pass=%0b alerts=%0d at %0d exp t=4097 pass=%0b",
               dk1, pass1, na1, ak1, ep1);
    else npass++;
    nchk++;
    if (dk3 !== 4097 || pass3 !== ep3 || na3 !== (ep3 ? 0 : 1) || (!ep3 && ak3 !== 4097))
      $display("FAIL cks_fail_dut3 got t=%0d pass=%0b alerts=%0d at %0d exp t=4097 pass=%0b",
               dk3, pass3, na3, ak3, ep3);
    else npass++;
    nchk++;
    if (re !== 0 || se !== 0) $display("FAIL cks_fail_port got rsp=%0d mem=%0d errors exp 0", re, se);
    else npass++;
  endtask

  task automatic test_host_midscan();
    int dk1, dk3, na1, na3, ak1, ak3, re, se;
    logic ep1, ep3;
    for (int i = 0; i < 4096; i++) rom[AW'(i)] = $urandom();
    ep1 = (model_sum() == EXP1);
    ep3 = (model_sum() == EXP3);
    run_scan(1000, 10, dk1, dk3, na1, na3, ak1, ak3, re, se);
    nchk++;
    if (dk1 !== 4107 || dk3 !== 4107)
      $display("FAIL midscan_done got t1=%0d t3=%0d exp 4107", dk1, dk3);
    else npass++;
    nchk++;
    if (pass1 !== ep1 || pass3 !== ep3 || na1 !== (ep1 ? 0 : 1) || na3 !== (ep3 ? 0 : 1))
      $display("FAIL midscan_pass got p1=%0b p3=%0b a1=%0d a3=%0d exp p1=%0b p3=%0b",
               pass1, pass3, na1, na3, ep1, ep3);
    else npass++;
    nchk++;
    if (re !== 0) $display("FAIL midscan_rsp got %0d errors exp 0", re); else npass++;
    nchk++;
    if (se !== 0) $display("FAIL midscan_mem got %0d errors exp 0", se); else npass++;
  endtask

  task automatic test_reset_midscan();
    int dk1, dk3, na1, na3, ak1, ak3, re, se;
    do_reset();
    repeat (2000) begin
      drive(1'b0, '0);
      @(negedge clk);
    end
    drive(1'b0, '0);
    nchk++;
    if (maddr1 !== AW'(2000) || maddr3 !== AW'(2000))
      $display("FAIL rstmid_addr got %0d/%0d exp 2000", maddr1, maddr3);
    else npass++;
    drive(1'b1, AW'($urandom));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (rv1 !== 1'b0 || rv3 !== 1'b0)
      $display("FAIL rstmid_inflight got v1=%0b v3=%0b exp 0", rv1, rv3);
    else npass++;
    run_scan(0, 0, dk1, dk3, na1, na3, ak1, ak3, re, se);
    nchk++;
    if (dk1 !== 4097 || dk3 !== 4097)
      $display("FAIL rstmid_done got t1=%0d t3=%0d exp 4097", dk1, dk3);
    else npass++;
    nchk++;
    if (re !== 0 || se !== 0) $display("FAIL rstmid_port got rsp=%0d mem=%0d errors exp 0", re, se);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_latency1();
    test_latency3();
    test_back_to_back_random();
    test_checksum_pass();
    test_checksum_fail();
    test_host_midscan();
    test_reset_midscan();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/rom_port.md
ROM_PORT -- requirements
Module: rom_port

Interface
REQ-001 Parameter AddrWidth, 12, word-address width of ROM macro (4096 words).
REQ-002 Parameter DataWidth, 32, ROM word width.
REQ-003 Parameter Latency, 1, total host read latency in cycles; legal range 1..4.
REQ-004 Parameter ExpChecksum, 32'h0, expected boot-scan checksum.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 req_i  input  1  host read request; always accepted, no grant.
REQ-008 addr_i  input  AddrWidth  host word address.
REQ-009 rvalid_o  output  1  host read data valid.
REQ-010 rdata_o  output  DataWidth  host read data; 0 when rvalid_o low.
REQ-011 mem_req_o  output  1  ROM macro read strobe.
REQ-012 mem_addr_o  output  AddrWidth  ROM macro word address.
REQ-013 mem_rdata_i  input  DataWidth  ROM macro data, valid exactly 1 cycle after mem_req_o.
REQ-014 check_done_o  output  1  boot scan complete (level, sticky until reset).
REQ-015 check_pass_o  output  1  scan checksum matched ExpChecksum; valid when check_done_o high.
REQ-016 alert_o  output  1  single-cycle pulse on checksum mismatch.

Function
REQ-017 Every host request shall produce exactly one rvalid_o pulse exactly Latency cycles after req_i was sampled high, in request order.
REQ-018 Back-to-back host requests shall be serviced at one per cycle with no bubbles.
REQ-019 Host requests shall take absolute priority: when req_i high, mem_req_o=1 and mem_addr_o=addr_i combinationally.
REQ-020 Each macro read shall carry a 1-bit tag (HOST/SCAN) delayed alongside it; only HOST-tagged returns drive rvalid_o/rdata_o.
REQ-021 Extra Latency-1 register stages shall delay HOST return data and valid; stages reset to 0.
REQ-022 Scan FSM states: SCAN_ISSUE, SCAN_DRAIN, DONE.
REQ-023 SCAN_ISSUE: in any cycle with req_i low, issue scan read at scan_addr, increment scan_addr; with req_i high, scan_addr holds.
REQ-024 SCAN_ISSUE -> SCAN_DRAIN when scan read of address 2^AddrWidth-1 is issued (no wrap to 0 reissue).
REQ-025 Each SCAN-tagged return updates acc <= {acc[30:0],acc[31]} ^ mem_rdata_i; acc resets to 0.
REQ-026 SCAN_DRAIN -> DONE on the edge that absorbs the last scan return; compare uses the updated acc.
REQ-027 Entering DONE: check_done_o=1; check_pass_o=(acc==ExpChecksum); alert_o pulses 1 cycle iff mismatch.
REQ-028 DONE is terminal until reset; no further scan reads; host service unaffected in all states.
REQ-029 mem_req_o=0 and mem_addr_o=0 in cycles with no host request and no scan issue.

Reset
REQ-030 Reset values: rvalid_o=0, rdata_o=0, check_done_o=0, check_pass_o=0, alert_o=0, state=SCAN_ISSUE, scan_addr=0, acc=0, all pipeline tags invalid.
REQ-031 Reset mid-scan or mid-read shall discard in-flight reads (no rvalid_o after release) and restart scan at address 0.
REQ-032 First scan read shall issue in the first cycle after rst_ni deasserts.

Structure
REQ-033 Package rom_port_pkg holds scan state enum, tag enum (HOST=0, SCAN=1), checksum rotate width constant.
REQ-034 Sub-module rom_port_rsp_pipe implements the parameterised Latency-1 valid/data delay line.
REQ-035 Implementation size target 120-400 lines RTL; no FIFOs (fixed latency, no backpressure).

Verification
REQ-036 Latency=1, ROM word 5=32'hDEAD_BEEF, req_i with addr_i=5 cycle t -> rvalid_o=1, rdata_o=32'hDEAD_BEEF at t+1 only.
REQ-037 Latency=3, requests addr 1,2,3 in consecutive cycles -> three consecutive rvalid_o pulses, data in order, starting 3 cycles after first req.
REQ-038 All-zero ROM except word 0=32'h1, ExpChecksum=32'h8000_0000, no host traffic -> check_done_o and check_pass_o rise 4097 cycles after reset release, alert_o stays 0.
REQ-039 All-zero ROM except word 4095=32'h1, ExpChecksum=0 -> check_done_o=1, check_pass_o=0, one-cycle alert_o pulse.
REQ-040 10 host requests injected mid-scan -> check_done_o delayed by exactly 10 cycles, all 10 host responses correct.
REQ-041 rst_ni asserted at scan address 2000 with a host read in flight -> no rvalid_o, scan restarts at 0, done 4097 cycles after release.
